// File: rtl/wb_hyperram_wbuf.sv
// Posted-write buffer in front of the HyperRAM Wishbone controller.
// Ports: wbs_* upstream slave, wbm_* downstream master, level_o fill count.
module wb_hyperram_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [DW/8-1:0]   wbs_sel_i,
  input  logic [AW-1:0]     wbs_adr_i,
  input  logic [DW-1:0]     wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DW-1:0]     wbs_dat_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int SW = DW / 8;
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] q_adr [DEPTH];
  logic [DW-1:0] q_dat [DEPTH];
  logic [SW-1:0] q_sel [DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic          empty, full;
  logic          req, push, pop;
  logic          start_wr, start_rd;
  logic          capture, rd_resp;
  logic          abort_q;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[IW-1:0] == rptr[IW-1:0]);
  assign level_o = wptr - rptr;

  // ack gating keeps a held strobe from being taken twice
  assign req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign push = req & wbs_we_i & ~full &
                ((state == IDLE) | (state == WR));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    start_wr = 1'b0;
    start_rd = 1'b0;
    capture  = 1'b0;
    rd_resp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nx = WR;
          start_wr = 1'b1;
        end else if (req && !wbs_we_i) begin
          state_nx = RD;
          start_rd = 1'b1;
        end
      end
      WR: begin
        if (wbm_ack_i) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      RD: begin
        if (wbm_ack_i) begin
          capture = 1'b1;
          // an abandoned read still finishes but is not acked upstream
          if (wbs_cyc_i && !abort_q) begin
            rd_resp  = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      q_adr[wptr[IW-1:0]] <= wbs_adr_i;
      q_dat[wptr[IW-1:0]] <= wbs_dat_i;
      q_sel[wptr[IW-1:0]] <= wbs_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wptr      <= '0;
      rptr      <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      abort_q   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      wbs_ack_o <= push | rd_resp;
      abort_q   <= (state == RD) && (abort_q || !wbs_cyc_i);
      if (capture) wbs_dat_o <= wbm_dat_i;
      if (start_wr) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= 1'b1;
        wbm_adr_o <= q_adr[rptr[IW-1:0]];
        wbm_dat_o <= q_dat[rptr[IW-1:0]];
        wbm_sel_o <= q_sel[rptr[IW-1:0]];
      end else if (start_rd) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= 1'b0;
        wbm_adr_o <= wbs_adr_i;
        wbm_sel_o <= wbs_sel_i;
      end else if (pop || capture) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_hyperram_wbuf.sv
// Directed self-checking bench for wb_hyperram_wbuf.
// Drives #1 after posedge, checks settled outputs at the same point.
module tb_wb_hyperram_wbuf;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic [2:0]  level_o;

  int checks = 0;
  int errors = 0;
  int lat;
  logic seen;
  logic [31:0] exp_q [$];
  logic [31:0] model [logic [31:0]];

  always #5 clk = ~clk;

  wb_hyperram_wbuf #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rstn),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .level_o  (level_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    output int l);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = a; dat = d; sel = s;
    l = 0;
    do begin
      tick();
      l++;
    end while (!wbs_ack_o && l < 20);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model[a] = d;
    tick();
  endtask

  task automatic drain_one(input logic [31:0] a,
                           input logic [31:0] d);
    int n = 0;
    while (!(wbm_cyc_o && wbm_stb_o) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_cyc", 64'(wbm_cyc_o), 64'd1);
    chk("drain_we", 64'(wbm_we_o), 64'd1);
    chk("drain_adr", 64'(wbm_adr_o), 64'(a));
    chk("drain_dat", 64'(wbm_dat_o), 64'(d));
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_ack", 64'(wbs_ack_o), 64'd0);
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_lvl", 64'(level_o), 64'd0);
    chk("rst_dat", 64'(wbs_dat_o), 64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // single write then drain
    wr(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, lat);
    chk("t1_lat", 64'(lat), 64'd1);
    chk("t1_lvl", 64'(level_o), 64'd1);
    chk("t1_sel", 64'(wbm_sel_o), 64'hF);
    drain_one(32'h3000_0010, 32'hDEAD_BEEF);
    chk("t1_lvl0", 64'(level_o), 64'd0);
    chk("t1_idle", 64'(wbm_cyc_o), 64'd0);

    // fill to full, fifth write stalls
    for (int i = 0; i < 4; i++) begin
      wr(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, lat);
      chk("t2_lat", 64'(lat), 64'd1);
    end
    chk("t2_full", 64'(level_o), 64'd4);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h210; dat = 32'hA4; sel = 4'h3;
    tick(); tick(); tick();
    chk("t2_noack", 64'(wbs_ack_o), 64'd0);
    chk("t2_lvl4", 64'(level_o), 64'd4);
    chk("t2_head", 64'(wbm_adr_o), 64'h200);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("t2_popack", 64'(wbs_ack_o), 64'd0);
    chk("t2_lvl3", 64'(level_o), 64'd3);
    tick();
    chk("t2_ack5", 64'(wbs_ack_o), 64'd1);
    chk("t2_relvl4", 64'(level_o), 64'd4);
    chk("t2_head1", 64'(wbm_adr_o), 64'h204);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    for (int i = 1; i < 5; i++)
      drain_one(32'h200 + 32'(i * 4), 32'hA0 + 32'(i));
    chk("t2_empty", 64'(level_o), 64'd0);

    // read after write
    wr(32'h08, 32'h1122_3344, 4'hF, lat);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = 32'h08; sel = 4'hF;
    drain_one(32'h08, 32'h1122_3344);
    lat = 0;
    while (!wbm_cyc_o && lat < 20) begin
      tick();
      lat++;
    end
    chk("t3_rd_cyc", 64'(wbm_cyc_o), 64'd1);
    chk("t3_rd_we", 64'(wbm_we_o), 64'd0);
    chk("t3_rd_adr", 64'(wbm_adr_o), 64'h08);
    wbm_dat_i = model[32'h08];
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("t3_ack", 64'(wbs_ack_o), 64'd1);
    chk("t3_dat", 64'(wbs_dat_o), 64'h1122_3344);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("t3_ack1", 64'(wbs_ack_o), 64'd0);

    // push and pop on the same edge across wrap
    exp_q.delete();
    wr(32'h100, 32'h0, 4'hF, lat);
    exp_q.push_back(32'h100);
    wr(32'h104, 32'h1, 4'hF, lat);
    exp_q.push_back(32'h104);
    chk("t4_lvl", 64'(level_o), 64'd2);
    for (int k = 0; k < 10; k++) begin
      chk("t4_head", 64'(wbm_adr_o), 64'(exp_q[0]));
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 32'h108 + 32'(k * 4); dat = 32'(k + 2);
      wbm_ack_i = 1'b1;
      tick();
      chk("t4_lvl2", 64'(level_o), 64'd2);
      chk("t4_ack", 64'(wbs_ack_o), 64'd1);
      void'(exp_q.pop_front());
      exp_q.push_back(adr);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      wbm_ack_i = 1'b0;
      tick();
    end
    drain_one(exp_q[0], exp_q[0] - 32'h100 >> 2);
    drain_one(exp_q[1], exp_q[1] - 32'h100 >> 2);
    chk("t4_empty", 64'(level_o), 64'd0);

    // read abort
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = 32'h40;
    tick();
    chk("t5_rd", 64'(wbm_cyc_o), 64'd1);
    chk("t5_we", 64'(wbm_we_o), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (5) tick();
    chk("t5_hold", 64'(wbm_cyc_o), 64'd1);
    wbm_dat_i = 32'hCAFE_F00D;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("t5_noack", 64'(wbs_ack_o), 64'd0);
    chk("t5_dat", 64'(wbs_dat_o), 64'hCAFE_F00D);
    chk("t5_cyc", 64'(wbm_cyc_o), 64'd0);
    tick();
    chk("t5_noack2", 64'(wbs_ack_o), 64'd0);
    chk("t5_idle", 64'(wbm_cyc_o), 64'd0);
    wr(32'h50, 32'h55, 4'hF, lat);
    chk("t5_wlat", 64'(lat), 64'd1);
    drain_one(32'h50, 32'h55);

    // asynchronous reset during a write beat
    wr(32'h60, 32'h6, 4'hF, lat);
    wr(32'h64, 32'h7, 4'hF, lat);
    wr(32'h68, 32'h8, 4'hF, lat);
    chk("t6_lvl3", 64'(level_o), 64'd3);
    chk("t6_wr", 64'(wbm_cyc_o), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("t6_stb", 64'(wbm_stb_o), 64'd0);
    chk("t6_lvl", 64'(level_o), 64'd0);
    chk("t6_ack", 64'(wbs_ack_o), 64'd0);
    tick(); tick();
    rstn = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | wbm_cyc_o;
    end
    chk("t6_quiet", 64'(seen), 64'd0);
    chk("t6_lvl0", 64'(level_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
